// File: rtl/gray_to_rgb.sv
// Two-stage gray-to-RGB expander with valid/ready flow control.
// Replicates gray into all channels, or tints each channel with a saturating Q8.8 gain.
module gray_to_rgb #(
    parameter int GAIN_W = 16,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        gray_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              mode,
    input  logic [GAIN_W-1:0] gain_r,
    input  logic [GAIN_W-1:0] gain_g,
    input  logic [GAIN_W-1:0] gain_b,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              sat_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  pix_count
);

    // Returns {clipped, channel}: gray * gain in Q8.8, fraction truncated, clipped to 8 bits.
    function automatic logic [8:0] tint_chan(input logic [7:0] gray, input logic [GAIN_W-1:0] gain);
        logic [GAIN_W+7:0] prod;
        logic [GAIN_W-1:0] quot;
        prod = {{GAIN_W{1'b0}}, gray} * {8'd0, gain};
        quot = GAIN_W'(prod >> 8);
        if (quot > GAIN_W'(8'hFF)) begin
            return {1'b1, 8'hFF};
        end else begin
            return {1'b0, quot[7:0]};
        end
    endfunction

    logic              s1_valid_r;
    logic [7:0]        s1_gray_r;
    logic              s1_mode_r;
    logic [GAIN_W-1:0] s1_gain_r_r;
    logic [GAIN_W-1:0] s1_gain_g_r;
    logic [GAIN_W-1:0] s1_gain_b_r;

    logic              en1_s;
    logic              en2_s;
    logic              out_xfer_s;
    logic [8:0]        tint_r_s;
    logic [8:0]        tint_g_s;
    logic [8:0]        tint_b_s;
    logic [7:0]        red_s;
    logic [7:0]        green_s;
    logic [7:0]        blue_s;
    logic              sat_s;

    // Pipeline enables: a stage advances when it is empty or the stage after it is moving.
    always_comb begin
        en2_s      = !valid_out || ready_in;
        en1_s      = !s1_valid_r || en2_s;
        out_xfer_s = valid_out && ready_in;
    end

    assign ready_out = en1_s;

    // Channel arithmetic on the pixel held in stage 1.
    always_comb begin
        tint_r_s = tint_chan(s1_gray_r, s1_gain_r_r);
        tint_g_s = tint_chan(s1_gray_r, s1_gain_g_r);
        tint_b_s = tint_chan(s1_gray_r, s1_gain_b_r);
        red_s    = s1_gray_r;
        green_s  = s1_gray_r;
        blue_s   = s1_gray_r;
        sat_s    = 1'b0;
        if (s1_mode_r) begin
            red_s   = tint_r_s[7:0];
            green_s = tint_g_s[7:0];
            blue_s  = tint_b_s[7:0];
            sat_s   = tint_r_s[8] | tint_g_s[8] | tint_b_s[8];
        end else begin
            sat_s   = 1'b0;
        end
    end

    // Stage 1: latch the accepted pixel together with its mode and gains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r  <= 1'b0;
            s1_gray_r   <= 8'd0;
            s1_mode_r   <= 1'b0;
            s1_gain_r_r <= {GAIN_W{1'b0}};
            s1_gain_g_r <= {GAIN_W{1'b0}};
            s1_gain_b_r <= {GAIN_W{1'b0}};
        end else if (en1_s) begin
            s1_valid_r <= valid_in;
            if (valid_in) begin
                s1_gray_r   <= gray_in;
                s1_mode_r   <= mode;
                s1_gain_r_r <= gain_r;
                s1_gain_g_r <= gain_g;
                s1_gain_b_r <= gain_b;
            end
        end
    end

    // Stage 2: output registers; data only loads with a real pixel so bubbles keep the last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            sat_out   <= 1'b0;
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
        end else if (en2_s) begin
            valid_out <= s1_valid_r;
            if (s1_valid_r) begin
                red_out   <= red_s;
                green_out <= green_s;
                blue_out  <= blue_s;
                sat_out   <= sat_s;
            end
        end
    end

    // Completed-transfer counter, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_count <= {CNT_W{1'b0}};
        end else if (out_xfer_s) begin
            pix_count <= pix_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_to_rgb.sv
// Randomized and directed bench for gray_to_rgb, scored against a queue-based reference model.
// A second instance with a 4-bit counter follows the same stream to observe counter wrap.
module tb_gray_to_rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  gray_in = 8'd0;
    logic        valid_in = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] gain_r = 16'd0;
    logic [15:0] gain_g = 16'd0;
    logic [15:0] gain_b = 16'd0;
    logic        ready_in = 1'b0;

    logic        ready_out, sat_out, valid_out;
    logic [7:0]  red_out, green_out, blue_out;
    logic [19:0] pix_count;
    logic        ready_out4, sat_out4, valid_out4;
    logic [7:0]  red_out4, green_out4, blue_out4;
    logic [3:0]  pix_count4;

    gray_to_rgb dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in), .ready_out(ready_out),
        .mode(mode), .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .sat_out(sat_out),
        .valid_out(valid_out), .ready_in(ready_in), .pix_count(pix_count)
    );

    gray_to_rgb #(.GAIN_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in), .ready_out(ready_out4),
        .mode(mode), .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .red_out(red_out4), .green_out(green_out4), .blue_out(blue_out4), .sat_out(sat_out4),
        .valid_out(valid_out4), .ready_in(ready_in), .pix_count(pix_count4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [24:0] exp_q[$];
    int          model_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [24:0] prev_out = 25'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel {sat, r, g, b}: replicate, or gray*gain/256 truncated and clipped at 255.
    function automatic logic [24:0] ref_pix(input int gray, input int m, input int gr, input int gg, input int gb);
        int ch[3];
        int gains[3];
        bit sat;
        sat = 1'b0;
        if (m == 0) return {1'b0, 8'(gray), 8'(gray), 8'(gray)};
        gains = '{gr, gg, gb};
        for (int i = 0; i < 3; i++) begin
            ch[i] = (gray * gains[i]) / 256;
            if (ch[i] > 255) begin
                ch[i] = 255;
                sat = 1'b1;
            end
        end
        return {sat, 8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
    endfunction

    // Monitor: sampled on the falling edge, mid-cycle between drive and capture.
    always @(negedge clk) begin
        if (mon_en) begin
            check_val("pix_count", 32'(pix_count), 32'(model_cnt % (1 << 20)));
            check_val("pix_count_w4", 32'(pix_count4), 32'(model_cnt % 16));
            check_val("ready_out", 32'(ready_out), 32'((exp_q.size() < 2) || ready_in));
            if (prev_stall)
                check_val("stall_hold", 32'({valid_out, sat_out, red_out, green_out, blue_out}),
                          32'({1'b1, prev_out}));
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 32'(1), 32'(0));
                end else begin
                    check_val("pixel", 32'({sat_out, red_out, green_out, blue_out}), 32'(exp_q.pop_front()));
                end
                model_cnt++;
            end
            prev_stall = valid_out && !ready_in;
            prev_out   = {sat_out, red_out, green_out, blue_out};
            if (valid_in && ready_out)
                exp_q.push_back(ref_pix(int'(gray_in), int'(mode), int'(gain_r), int'(gain_g), int'(gain_b)));
        end
    end

    // Random backpressure source.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
    end

    // Offer one pixel and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] g, input logic m, input logic [15:0] gr, input logic [15:0] gg,
                        input logic [15:0] gb);
        bit acc;
        int n;
        gray_in = g; mode = m; gain_r = gr; gain_g = gg; gain_b = gb; valid_in = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_val("send_timeout", 32'(0), 32'(1));
        valid_in = 1'b0;
        gray_in  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        valid_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        prev_stall = 1'b0;
        mon_en = 1'b1;
    endtask

    // Directed single pixel from an empty pipeline with the sink ready.
    task automatic one_pixel(input string tag, input logic [7:0] g, input logic m, input logic [15:0] gr,
                             input logic [15:0] gg, input logic [15:0] gb, input logic [24:0] exp);
        send(g, m, gr, gg, gb);
        check_val({tag, "_lat1"}, 32'(valid_out), 32'(0));
        @(posedge clk);
        #1;
        check_val({tag, "_valid"}, 32'(valid_out), 32'(1));
        check_val({tag, "_rgb"}, 32'({sat_out, red_out, green_out, blue_out}), 32'(exp));
    endtask

    initial begin
        // Reset held with random inputs toggling.
        repeat (3) begin
            @(posedge clk);
            #1;
            valid_in = 1'($urandom); gray_in = 8'($urandom); mode = 1'($urandom);
            gain_r = 16'($urandom); ready_in = 1'($urandom);
        end
        check_val("rst_outputs", 32'({valid_out, sat_out, red_out, green_out, blue_out}), 32'(0));
        check_val("rst_count", 32'(pix_count), 32'(0));
        check_val("rst_ready", 32'(ready_out), 32'(1));
        valid_in = 1'b0;
        ready_in = 1'b1;
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_after_rst", 32'(valid_out), 32'(0));

        // Replicate, tint, saturation and zero.
        one_pixel("replicate", 8'h80, 1'b0, 16'h0100, 16'h0080, 16'h0200, {1'b0, 24'h808080});
        @(posedge clk);
        #1;
        check_val("count_one", 32'(pix_count), 32'(1));
        one_pixel("tint", 8'h64, 1'b1, 16'h0100, 16'h0080, 16'h0200, {1'b0, 24'h6432C8});
        one_pixel("saturate", 8'hC8, 1'b1, 16'h0100, 16'h0080, 16'h0200, {1'b1, 24'hC864FF});
        one_pixel("zero_gray", 8'h00, 1'b1, 16'h0100, 16'h0080, 16'h0200, {1'b0, 24'h000000});
        one_pixel("zero_gain", 8'hFF, 1'b1, 16'h0000, 16'h0100, 16'h01FF, {1'b1, 24'h00FFFF});
        drain();

        // Backpressure: fill both stages, hold four cycles, then release.
        do_reset();
        ready_in = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send(8'(k), 1'b0, 16'h0100, 16'h0100, 16'h0100);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check_val("bp_ready_low", 32'(ready_out), 32'(0));
                ready_in = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    check_val("bp_flow_valid", 32'(valid_out), 32'(1));
                    check_val("bp_flow_order", 32'(red_out), 32'(k));
                    @(posedge clk);
                    #1;
                end
                check_val("bp_count", 32'(pix_count), 32'(4));
            end
        join

        // Reset with two pixels in flight.
        ready_in = 1'b0;
        send(8'hA1, 1'b0, 16'h0100, 16'h0100, 16'h0100);
        send(8'hA2, 1'b0, 16'h0100, 16'h0100, 16'h0100);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check_val("async_rst", 32'({valid_out, red_out, pix_count[7:0]}), 32'(0));
        check_val("async_rst_ready", 32'(ready_out), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        prev_stall = 1'b0;
        mon_en = 1'b1;
        ready_in = 1'b1;
        send(8'h10, 1'b0, 16'h0100, 16'h0100, 16'h0100);
        @(posedge clk);
        #1;
        check_val("midrst_pixel", 32'({valid_out, red_out}), 32'({1'b1, 8'h10}));
        drain();
        check_val("midrst_count", 32'(pix_count), 32'(1));

        // Counter wrap on the 4-bit instance.
        do_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 17; k++) send(8'($urandom), 1'($urandom), 16'($urandom), 16'h0100, 16'h0040);
        drain();
        check_val("wrap_count4", 32'(pix_count4), 32'(1));
        check_val("wrap_count20", 32'(pix_count), 32'(17));

        // Randomized stream under random backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic [15:0] gs[3];
            for (int c = 0; c < 3; c++) begin
                case ($urandom_range(0, 3))
                    0:       gs[c] = 16'h0000;
                    1:       gs[c] = 16'h0100;
                    2:       gs[c] = 16'($urandom_range(0, 16'h0200));
                    default: gs[c] = 16'($urandom);
                endcase
            end
            send(8'($urandom), 1'($urandom), gs[0], gs[1], gs[2]);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        ready_in = 1'b1;
        drain();
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
